// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a multicycle MIPS-like datapath. Each state
// decodes a fixed set of datapath controls. irwrite, pcen and memwrite are
// also gated by the memory handshake and the ALU flags, so the datapath only
// commits a fetch, branch or store in the cycle it actually completes.
//
// Parameters
//   USE_READY  1: FETCH/MEMRD/MEMWR wait for mem_ready
//              0: mem_ready is treated as constant 1 (single-cycle memory)
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous active-low reset
//   op, funct   instruction fields from the instruction register
//   zero, ltez  ALU result flags (result == 0, result <= 0)
//   mem_ready   memory access completes this cycle
//   iord .. alusrca          1-bit datapath controls
//   alusrcb, pcsrc           ALU B / next-PC mux selects
//   alucontrol               ALU operation code
//   state                    current FSM state code
//   illegal_op               one-cycle pulse on unsupported op or funct
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit USE_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       ltez,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [2:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IWB     = 4'd10,
        JEX     = 4'd11,
        LUIEX   = 4'd12,
        BLEZEX  = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BLEZ = 6'b000110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t state_q, state_d;
    logic   ready;

    // With USE_READY=0 every memory state completes in one cycle.
    assign ready = USE_READY ? mem_ready : 1'b1;
    assign state = state_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; the async reset drops straight to FETCH,
    // abandoning any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output and state_d gets a default before the case so no
    // path leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 3'b000;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        illegal_op = 1'b0;

        unique case (state_q)
            FETCH: begin
                alusrcb = 3'b001;
                if (ready) begin
                    // Gated by reset so nothing commits while reset is held.
                    irwrite = reset;
                    pcen    = reset;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alusrcb = 3'b011;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    OP_LUI:       state_d = LUIEX;
                    OP_BLEZ:      state_d = BLEZEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (ready) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = ready;
                if (ready) state_d = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                state_d = RTYPEWB;
                case (funct)
                    FN_ADD: alucontrol = ALU_ADD;
                    FN_SUB: alucontrol = ALU_SUB;
                    FN_AND: alucontrol = ALU_AND;
                    FN_OR:  alucontrol = ALU_OR;
                    FN_SLT: alucontrol = ALU_SLT;
                    FN_SLL: alucontrol = ALU_SLL;
                    FN_SRL: alucontrol = ALU_SRL;
                    default: begin
                        // Unknown funct: skip writeback entirely.
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
                state_d    = FETCH;
            end
            BLEZEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = ltez;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
                state_d = IWB;
            end
            LUIEX: begin
                // {imm,16'h0} OR rs, with rs=$0 by convention.
                alusrca    = 1'b1;
                alusrcb    = 3'b100;
                alucontrol = ALU_OR;
                state_d    = IWB;
            end
            IWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = FETCH;
            end
            default: begin
                // Unused codes 14/15: everything off, recover to FETCH.
                alucontrol = 4'b0000;
                state_d    = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. One task per scenario; each drives
// inputs just after a rising edge and compares outputs a little later, well
// away from either clock edge. A second instance with USE_READY=0 shares the
// inputs and is exercised at the end.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BLEZ = 6'b000110;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       ltez;
    logic       mem_ready;

    logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic [3:0] state;
    logic       illegal_op;

    logic       iord_nr, memwrite_nr, irwrite_nr, pcen_nr, regdst_nr, memtoreg_nr;
    logic       regwrite_nr, alusrca_nr;
    logic [2:0] alusrcb_nr;
    logic [1:0] pcsrc_nr;
    logic [3:0] alucontrol_nr;
    logic [3:0] state_nr;
    logic       illegal_op_nr;

    int checks;
    int errors;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .ltez(ltez),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcen(pcen), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .state(state), .illegal_op(illegal_op)
    );

    multicycle_controller #(.USE_READY(1'b0)) dut_nr (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .ltez(ltez),
        .mem_ready(mem_ready), .iord(iord_nr), .memwrite(memwrite_nr),
        .irwrite(irwrite_nr), .pcen(pcen_nr), .regdst(regdst_nr),
        .memtoreg(memtoreg_nr), .regwrite(regwrite_nr), .alusrca(alusrca_nr),
        .alusrcb(alusrcb_nr), .pcsrc(pcsrc_nr), .alucontrol(alucontrol_nr),
        .state(state_nr), .illegal_op(illegal_op_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values while held, then first edge after release does a FETCH.
    task automatic test_reset();
        logic [22:0] got, expv;
        reset = 1'b0; op = OP_J; mem_ready = 1'b1;
        #2;
        got  = {state, irwrite, pcen, illegal_op, alusrcb, alucontrol, iord, alusrca, pcsrc,
                regwrite, memwrite};
        expv = {4'd0, 1'b0, 1'b0, 1'b0, 3'b001, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        checks++;
        if (got !== expv) begin
            errors++; $display("FAIL reset_values: got %b expected %b", got, expv);
        end
        tick();
        checks++;
        if ({state, irwrite, pcen} !== {4'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_held: got %0d/%b%b expected 0/00", state, irwrite, pcen);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({state, irwrite, pcen} !== {4'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL fetch_after_release: got %0d/%b%b expected 0/11", state, irwrite, pcen);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++; $display("FAIL first_edge_decode: got %0d expected 1", state);
        end
        tick();
        checks++;
        if ({state, pcen, pcsrc} !== {4'd11, 1'b1, 2'b10}) begin
            errors++; $display("FAIL jex: got %0d/%b/%b expected 11/1/10", state, pcen, pcsrc);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL j_return: got %0d expected 0", state);
        end
    endtask

    // lw, zero wait: 0,1,2,3,4,0; regwrite+memtoreg only in MEMWB.
    task automatic test_lw();
        int exp_s[6];
        logic [5:0] got, expv;
        exp_s = '{0, 1, 2, 3, 4, 0};
        op = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            #1;
            got  = {state, regwrite, memtoreg};
            expv = {4'(exp_s[i]), exp_s[i] == 4, exp_s[i] == 4};
            checks++;
            if (got !== expv) begin
                errors++; $display("FAIL lw_cycle%0d: got %b expected %b", i, got, expv);
            end
        end
    endtask

    // sw with 3 wait cycles in MEMWR; mem_ready low in DECODE/MEMADR is ignored.
    task automatic test_sw();
        int   exp_s[8];
        logic rdy[8];
        logic [5:0] got, expv;
        exp_s = '{0, 1, 2, 5, 5, 5, 5, 0};
        rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = OP_SW;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i];
            #1;
            got  = {state, memwrite, iord};
            expv = {4'(exp_s[i]), i == 6, exp_s[i] == 5};
            checks++;
            if (got !== expv) begin
                errors++; $display("FAIL sw_cycle%0d: got %b expected %b", i, got, expv);
            end
        end
        mem_ready = 1'b1;
    endtask

    // beq/blez with both flag values; also a stalled FETCH first.
    task automatic test_branch();
        logic [5:0] ops[4];
        logic       zs[4], ls[4], pe[4];
        int         es[4];
        logic [14:0] got, expv;
        ops = '{OP_BEQ, OP_BEQ, OP_BLEZ, OP_BLEZ};
        zs  = '{1'b0, 1'b1, 1'b0, 1'b1};
        ls  = '{1'b1, 1'b0, 1'b1, 1'b0};
        pe  = '{1'b0, 1'b1, 1'b1, 1'b0};
        es  = '{8, 8, 13, 13};
        for (int c = 0; c < 4; c++) begin
            op = ops[c]; zero = zs[c]; ltez = ls[c]; mem_ready = 1'b0;
            #1;
            checks++;
            if ({state, irwrite, pcen} !== {4'd0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL fetch_stall%0d: got %0d/%b%b expected 0/00", c, state, irwrite, pcen);
            end
            tick();
            mem_ready = 1'b1;
            #1;
            checks++;
            if ({state, irwrite, pcen} !== {4'd0, 1'b1, 1'b1}) begin
                errors++; $display("FAIL fetch_go%0d: got %0d/%b%b expected 0/11", c, state, irwrite, pcen);
            end
            tick(); tick();
            got  = {state, pcen, pcsrc, alucontrol, alusrca, alusrcb};
            expv = {4'(es[c]), pe[c], 2'b01, 4'b0110, 1'b1, 3'b000};
            checks++;
            if (got !== expv) begin
                errors++; $display("FAIL branch%0d: got %b expected %b", c, got, expv);
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                errors++; $display("FAIL branch_return%0d: got %0d expected 0", c, state);
            end
        end
        zero = 1'b0; ltez = 1'b0;
    endtask

    // R-type decode of several functs, then an unsupported funct.
    task automatic test_rtype();
        logic [5:0] fn[3];
        logic [3:0] al[3];
        logic [12:0] got, expv;
        fn = '{6'b100000, 6'b100010, 6'b000010};
        al = '{4'b0010, 4'b0110, 4'b0100};
        op = OP_R; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            funct = fn[c];
            tick(); tick();
            got  = {state, alucontrol, alusrca, alusrcb, illegal_op};
            expv = {4'd6, al[c], 1'b1, 3'b000, 1'b0};
            checks++;
            if (got !== expv) begin
                errors++; $display("FAIL rtype_ex%0d: got %b expected %b", c, got, expv);
            end
            tick();
            checks++;
            if ({state, regdst, regwrite, memtoreg} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
                errors++; $display("FAIL rtype_wb%0d: got %0d/%b%b%b expected 7/110", c, state, regdst, regwrite, memtoreg);
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                errors++; $display("FAIL rtype_return%0d: got %0d expected 0", c, state);
            end
        end
        funct = 6'b111111;
        tick(); tick();
        checks++;
        if ({state, illegal_op, regwrite} !== {4'd6, 1'b1, 1'b0}) begin
            errors++; $display("FAIL bad_funct: got %0d/%b%b expected 6/10", state, illegal_op, regwrite);
        end
        tick();
        checks++;
        if ({state, illegal_op, regwrite} !== {4'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL bad_funct_return: got %0d/%b%b expected 0/00", state, illegal_op, regwrite);
        end
        funct = 6'b000000;
    endtask

    // lui: 0,1,12,10,0 with full per-state control check.
    task automatic test_lui();
        logic [13:0] exp_v[5];
        logic [13:0] got;
        // {state, alusrcb, alucontrol, regwrite, regdst, alusrca}
        exp_v = '{{4'd0,  3'b001, 4'b0010, 1'b0, 1'b0, 1'b0},
                  {4'd1,  3'b011, 4'b0010, 1'b0, 1'b0, 1'b0},
                  {4'd12, 3'b100, 4'b0001, 1'b0, 1'b0, 1'b1},
                  {4'd10, 3'b000, 4'b0010, 1'b1, 1'b0, 1'b0},
                  {4'd0,  3'b001, 4'b0010, 1'b0, 1'b0, 1'b0}};
        op = OP_LUI; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            got = {state, alusrcb, alucontrol, regwrite, regdst, alusrca};
            checks++;
            if (got !== exp_v[i]) begin
                errors++; $display("FAIL lui_cycle%0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
    endtask

    // addi path and an unsupported opcode.
    task automatic test_misc();
        op = OP_ADDI; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({state, alusrca, alusrcb, alucontrol} !== {4'd9, 1'b1, 3'b010, 4'b0010}) begin
            errors++; $display("FAIL addi_ex: got %0d/%b/%b/%b expected 9/1/010/0010", state, alusrca, alusrcb, alucontrol);
        end
        tick();
        checks++;
        if ({state, regwrite, regdst, memtoreg} !== {4'd10, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL addi_wb: got %0d/%b%b%b expected 10/100", state, regwrite, regdst, memtoreg);
        end
        tick();
        op = 6'b111111;
        tick();
        checks++;
        if ({state, illegal_op} !== {4'd1, 1'b1}) begin
            errors++; $display("FAIL bad_op: got %0d/%b expected 1/1", state, illegal_op);
        end
        tick();
        checks++;
        if ({state, illegal_op} !== {4'd0, 1'b0}) begin
            errors++; $display("FAIL bad_op_return: got %0d/%b expected 0/0", state, illegal_op);
        end
    endtask

    // Async reset while in RTYPEWB: immediate FETCH, no regwrite.
    task automatic test_reset_mid();
        op = OP_R; funct = 6'b100000; mem_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({state, regwrite} !== {4'd7, 1'b1}) begin
            errors++; $display("FAIL mid_setup: got %0d/%b expected 7/1", state, regwrite);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({state, regwrite, illegal_op} !== {4'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_async: got %0d/%b%b expected 0/00", state, regwrite, illegal_op);
        end
        tick();
        checks++;
        if ({state, regwrite, irwrite, pcen} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_held: got %0d/%b%b%b expected 0/000", state, regwrite, irwrite, pcen);
        end
        @(negedge clk);
        reset = 1'b1; op = OP_J;
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++; $display("FAIL mid_restart: got %0d expected 1", state);
        end
        tick(); tick();
    endtask

    // USE_READY=0: sw completes with mem_ready held low; the waiting
    // instance stays in FETCH meanwhile.
    task automatic test_no_ready();
        int exp_s[5];
        logic [9:0] got, expv;
        exp_s = '{0, 1, 2, 5, 0};
        reset = 1'b0;
        #1;
        @(negedge clk);
        op = OP_SW; mem_ready = 1'b0; reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            got  = {state_nr, memwrite_nr, irwrite_nr, state};
            expv = {4'(exp_s[i]), exp_s[i] == 5, exp_s[i] == 0, 4'd0};
            checks++;
            if (got !== expv) begin
                errors++; $display("FAIL noready_cycle%0d: got %b expected %b", i, got, expv);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0; ltez = 1'b0; mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_rtype();
        test_lui();
        test_misc();
        test_reset_mid();
        test_no_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter USE_READY, default 1, meaning 1 = memory states wait for mem_ready and 0 = mem_ready is treated as constant 1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports op and funct, input, 6 each, instruction fields taken from the instruction register.
REQ-005 SHALL have ports zero and ltez, input, 1 each, ALU result flags (==0, <=0).
REQ-006 SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-007 SHALL have ports iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca, output, 1 each, datapath controls.
REQ-008 SHALL have ports alusrcb (3), pcsrc (2), alucontrol (4), state (4), all outputs.
REQ-009 SHALL have port illegal_op, output, 1, one-cycle pulse on an unsupported op or funct.

Function
REQ-010 SHALL be a Moore FSM; outputs decode from state, except that irwrite, pcen and memwrite are also gated by mem_ready and the flags.
REQ-011 SHALL use fixed state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IWB=10, JEX=11, LUIEX=12, BLEZEX=13; the state output equals the current code.
REQ-012 SHALL use these opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010, lui 001111, blez 000110.
REQ-013 FETCH: iord=0, alusrca=0, alusrcb=001 (+4), alucontrol=ADD, pcsrc=00; while mem_ready=0, stay in FETCH with irwrite=0 and pcen=0; when mem_ready=1, assert irwrite=1 and pcen=1 and go to DECODE.
REQ-014 DECODE: alusrca=0, alusrcb=011 (signimm<<2), alucontrol=ADD; the next state is chosen by op: lw/sw->MEMADR, R->RTYPEEX, beq->BEQEX, addi->ADDIEX, j->JEX, lui->LUIEX, blez->BLEZEX.
REQ-015 DECODE with any other op: pulse illegal_op=1 and go to FETCH.
REQ-016 MEMADR: alusrca=1, alusrcb=010 (signimm), ADD; go to MEMRD if op=lw, else MEMWR.
REQ-017 MEMRD: iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: regdst=0, memtoreg=1, regwrite=1, then go to FETCH.
REQ-019 MEMWR: iord=1, memwrite=mem_ready; hold until mem_ready=1, then go to FETCH.
REQ-020 RTYPEEX: alusrca=1, alusrcb=000, alucontrol from funct: 100000 ADD=0010, 100010 SUB=0110, 100100 AND=0000, 100101 OR=0001, 101010 SLT=0111, 000000 SLL=0011, 000010 SRL=0100.
REQ-021 RTYPEEX with an unlisted funct: pulse illegal_op and go to FETCH with no write; otherwise go to RTYPEWB.
REQ-022 RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then go to FETCH.
REQ-023 BEQEX: alusrca=1, alusrcb=000, SUB, pcsrc=01, pcen=zero, then go to FETCH.
REQ-024 BLEZEX: same as BEQEX but pcen=ltez, then go to FETCH.
REQ-025 ADDIEX: alusrca=1, alusrcb=010, ADD, then go to IWB.
REQ-026 LUIEX: alusrca=1, alusrcb=100 ({imm,16'h0}), OR with srca ignored (alusrca=1 and rs=0 by convention), then go to IWB.
REQ-027 IWB: regdst=0, memtoreg=0, regwrite=1, then go to FETCH.
REQ-028 JEX: pcsrc=10, pcen=1, then go to FETCH.
REQ-029 Every control not listed for a state SHALL be 0, and alucontrol SHALL be ADD.
REQ-030 Unused codes 14 and 15 SHALL drive all controls 0 and go to FETCH next cycle.
REQ-031 Zero-wait latencies SHALL be: lw 5 cycles; sw, R-type, addi, lui 4; beq, blez, j 3.
REQ-032 mem_ready outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-033 With USE_READY=0, FETCH, MEMRD and MEMWR SHALL each last exactly one cycle.

Reset
REQ-034 reset=0 SHALL immediately force state=FETCH and illegal_op=0 without waiting for clk; outputs take FETCH values with irwrite=pcen=0 while reset=0.
REQ-035 Reset asserted mid-instruction SHALL abandon it; no regwrite or memwrite occurs after the asserting edge.
REQ-036 After reset is released, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-037 Check lw, op=100011, mem_ready=1: states 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1.
REQ-038 Check sw with mem_ready low for 3 cycles in MEMWR: state 5 held for 4 cycles; memwrite=1 only on the final cycle.
REQ-039 Check beq with zero=0 then zero=1, and blez with ltez=1: pcen in state 8/13 equals the flag; pcsrc=01.
REQ-040 Check R-type funct=000010 then funct=111111: first gives alucontrol=0100 and regdst=1 in RTYPEWB; second pulses illegal_op and returns to 0 without regwrite.
REQ-041 Check lui op=001111: states 0,1,12,10,0; alusrcb=100 in state 12; regwrite=1, regdst=0 in state 10.
REQ-042 Check reset dropped asynchronously in state 7: state=0 before the next edge, and no regwrite pulse.
